// File: rtl/io_mmio_resp.sv
// io_mmio_resp: MMIO responder for a UART byte path plus cycle and retired-instruction counters.
// Define IO_RX_FIFO_EN for an RX_FIFO_DEPTH-entry RX FIFO; otherwise RX is a single-byte register.
module io_mmio_resp #(
   parameter int RX_FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  wbe,
   input  logic        re,
   output logic [31:0] rdata,
   input  logic        inst_retire,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);
   localparam logic [31:0] A_STATUS = 32'h8000_0000;
   localparam logic [31:0] A_RX     = 32'h8000_0004;
   localparam logic [31:0] A_TX     = 32'h8000_0008;
   localparam logic [31:0] A_CYC    = 32'h8000_0010;
   localparam logic [31:0] A_INST   = 32'h8000_0014;
   localparam logic [31:0] A_CLR    = 32'h8000_0018;

   if (RX_FIFO_DEPTH < 2 || RX_FIFO_DEPTH > 64 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("RX_FIFO_DEPTH must be a power of two in 2..64");
   end

   logic        tx_store, clr, pop, push, rx_avail, rx_full;
   logic [7:0]  rx_head;
   logic [31:0] rdata_q, rdata_d, cyc_q, cyc_d, inst_q, inst_d;
   logic        tx_valid_q, tx_valid_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        unused_ok;

   assign unused_ok = ^wdata[31:8];

   always_comb begin
      tx_store   = |wbe && addr == A_TX && !tx_valid_q;
      clr        = |wbe && addr == A_CLR;
      pop        = re && addr == A_RX && rx_avail;
      push       = rx_valid && !rx_full;
      tx_valid_d = tx_store || (tx_valid_q && !tx_ready);
      tx_data_d  = tx_store ? wdata[7:0] : tx_data_q;
      cyc_d      = clr ? '0 : cyc_q + 32'd1;
      inst_d     = clr ? '0 : inst_q + {31'd0, inst_retire};
      rdata_d    = !re ? rdata_q
                 : addr == A_STATUS ? {30'd0, rx_avail, !tx_valid_q}
                 : addr == A_RX     ? {24'd0, rx_avail ? rx_head : 8'd0}
                 : addr == A_CYC    ? cyc_q
                 : addr == A_INST   ? inst_q
                 : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q    <= '0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= '0;
         cyc_q      <= '0;
         inst_q     <= '0;
      end else begin
         rdata_q    <= rdata_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         cyc_q      <= cyc_d;
         inst_q     <= inst_d;
      end
   end

`ifdef IO_RX_FIFO_EN
   localparam int AW = $clog2(RX_FIFO_DEPTH);
   logic [7:0]    mem_q [RX_FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   cnt_q, cnt_d;

   always_comb begin
      wr_d  = push ? wr_q + 1'b1 : wr_q;
      rd_d  = pop ? rd_q + 1'b1 : rd_q;
      cnt_d = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   end

   assign rx_avail = cnt_q != '0;
   assign rx_full  = cnt_q == (AW + 1)'(RX_FIFO_DEPTH);
   assign rx_head  = mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= rx_data;
   end
`else
   logic       rx_full_q, rx_full_d;
   logic [7:0] rx_hold_q, rx_hold_d;

   always_comb begin
      rx_full_d = push || (rx_full_q && !pop);
      rx_hold_d = push ? rx_data : rx_hold_q;
   end

   assign rx_avail = rx_full_q;
   assign rx_full  = rx_full_q;
   assign rx_head  = rx_hold_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_full_q <= 1'b0;
         rx_hold_q <= '0;
      end else begin
         rx_full_q <= rx_full_d;
         rx_hold_q <= rx_hold_d;
      end
   end
`endif

   assign rdata    = rdata_q;
   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign rx_ready = !rx_full;
endmodule

// File: tb/tb_io_mmio_resp.sv
// tb_io_mmio_resp: directed and random checks of io_mmio_resp against a queue-based reference model.
module tb_io_mmio_resp;
   localparam logic [31:0] A_STATUS = 32'h8000_0000;
   localparam logic [31:0] A_RX     = 32'h8000_0004;
   localparam logic [31:0] A_TX     = 32'h8000_0008;
   localparam logic [31:0] A_CYC    = 32'h8000_0010;
   localparam logic [31:0] A_INST   = 32'h8000_0014;
   localparam logic [31:0] A_CLR    = 32'h8000_0018;
`ifdef IO_RX_FIFO_EN
   localparam int CAP = 8;
`else
   localparam int CAP = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0, wdata = '0, rdata;
   logic [3:0]  wbe = '0;
   logic        re = 1'b0, inst_retire = 1'b0;
   logic [7:0]  tx_data, rx_data = '0;
   logic        tx_valid, tx_ready = 1'b0, rx_valid = 1'b0, rx_ready;

   int n_checks = 0;
   int n_fail = 0;

   logic [31:0] m_rdata, m_cyc, m_inst;
   logic        m_txv;
   logic [7:0]  m_txd;
   logic [7:0]  rxq [$];

   io_mmio_resp #(.RX_FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wbe(wbe), .re(re), .rdata(rdata),
      .inst_retire(inst_retire), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mval(input logic [31:0] a);
      if (a == A_STATUS) return {30'd0, rxq.size() != 0, !m_txv};
      if (a == A_RX) return rxq.size() != 0 ? {24'd0, rxq[0]} : 32'd0;
      if (a == A_CYC) return m_cyc;
      if (a == A_INST) return m_inst;
      return 32'd0;
   endfunction

   function automatic void model_tick();
      int sz;
      if (rst) begin
         m_rdata = '0; m_txv = 1'b0; m_txd = '0; m_cyc = '0; m_inst = '0;
         rxq.delete();
         return;
      end
      sz = rxq.size();
      if (re) m_rdata = mval(addr);
      if (wbe != 0 && addr == A_TX && !m_txv) begin
         m_txv = 1'b1;
         m_txd = wdata[7:0];
      end else if (m_txv && tx_ready) m_txv = 1'b0;
      if (wbe != 0 && addr == A_CLR) begin
         m_cyc = '0;
         m_inst = '0;
      end else begin
         m_cyc = m_cyc + 32'd1;
         m_inst = m_inst + {31'd0, inst_retire};
      end
      if (re && addr == A_RX && sz > 0) void'(rxq.pop_front());
      if (rx_valid && sz < CAP) rxq.push_back(rx_data);
   endfunction

   task automatic tick();
      model_tick();
      @(posedge clk);
      #1;
      chk("rdata", rdata, m_rdata);
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, m_txv});
      chk("tx_data", {24'd0, tx_data}, {24'd0, m_txd});
      chk("rx_ready", {31'd0, rx_ready}, {31'd0, rxq.size() < CAP});
   endtask

   task automatic ld(input logic [31:0] a);
      addr = a; re = 1'b1;
      tick();
      re = 1'b0; addr = '0;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; wbe = 4'hF;
      tick();
      wbe = '0; addr = '0; wdata = '0;
   endtask

   task automatic push(input logic [7:0] d);
      rx_valid = 1'b1; rx_data = d;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      logic [31:0] ra [8];
      ra = '{A_STATUS, A_RX, A_TX, A_CYC, A_INST, A_CLR, 32'h8000_0020, 32'h1000_0008};
      repeat (2) tick();
      rst = 1'b0;
      chk("reset_rdata", rdata, 32'd0);
      chk("reset_rx_ready", {31'd0, rx_ready}, 32'd1);
      ld(A_STATUS);
      chk("status_after_reset", rdata, 32'h1);
      ld(A_RX);
      chk("rx_empty_load", rdata, 32'h0);

      st(A_TX, 32'h41);
      repeat (5) tick();
      chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
      chk("tx_hold_data", {24'd0, tx_data}, 32'h41);
      st(A_TX, 32'h42);
      chk("tx_drop_second", {24'd0, tx_data}, 32'h41);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      chk("tx_handshake_done", {31'd0, tx_valid}, 32'd0);
      ld(A_STATUS);
      chk("tx_empty_status", rdata, 32'h1);
      st(A_TX, 32'h55);
      tx_ready = 1'b1;
      st(A_TX, 32'h66);
      tx_ready = 1'b0;
      chk("tx_store_in_handshake", {31'd0, tx_valid}, 32'd0);
      chk("tx_data_kept", {24'd0, tx_data}, 32'h55);

      push(8'h11); push(8'h22); push(8'h33);
      ld(A_STATUS);
      chk("rx_status", rdata, 32'h3);
      ld(A_RX);
      chk("rx_first", rdata, 32'h11);
      ld(A_RX); ld(A_RX); ld(A_RX);
      chk("rx_fourth", rdata, 32'h0);
      ld(A_STATUS);
      chk("rx_drained_status", rdata, 32'h1);

      rx_valid = 1'b1;
      for (int i = 0; i < CAP + 2; i++) begin
         rx_data = 8'($urandom);
         tick();
      end
      rx_valid = 1'b0;
      chk("rx_full_ready", {31'd0, rx_ready}, 32'd0);
      ld(A_RX);
      chk("rx_pop_ready", {31'd0, rx_ready}, 32'd1);
      for (int i = 0; i < CAP; i++) ld(A_RX);

      st(A_CLR, 32'hDEAD_BEEF);
      for (int i = 0; i < 100; i++) begin
         inst_retire = i < 40;
         tick();
      end
      inst_retire = 1'b0;
      ld(A_CYC);
      chk("cycle_count_100", rdata, 32'd100);
      ld(A_INST);
      chk("inst_count_40", rdata, 32'd40);
      st(A_CLR, 32'h0);
      ld(A_CYC);
      chk("cycle_after_clear", rdata, 32'd0);

      push(8'h5A);
      ld(A_STATUS);
      ld(32'h8000_0020);
      chk("unmapped_in_region", rdata, 32'd0);
      ld(A_STATUS);
      ld(32'h1000_0000);
      chk("outside_region", rdata, 32'd0);
      st(32'h8000_0020, 32'h77);
      st(32'h1000_0008, 32'h78);
      st(32'h1000_0018, 32'h0);
      chk("foreign_store_tx", {31'd0, tx_valid}, 32'd0);
      ld(A_INST);
      ld(A_RX);
      chk("foreign_store_rx", rdata, 32'h5A);

      addr = A_TX; wdata = 32'h99; wbe = 4'h1; re = 1'b1;
      tick();
      addr = A_STATUS;
      tick();
      re = 1'b0; wbe = '0;
      chk("re_wbe_store_took", {24'd0, tx_data}, 32'h99);
      chk("re_wbe_pre_state", rdata, 32'h0);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;

      for (int i = 0; i < 600; i++) begin
         addr        = ra[$urandom_range(7)];
         re          = ($urandom_range(2) == 0);
         wbe         = ($urandom_range(3) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
         wdata       = $urandom;
         inst_retire = 1'($urandom);
         rx_valid    = 1'($urandom);
         rx_data     = 8'($urandom);
         tx_ready    = 1'($urandom);
         tick();
      end
      re = 1'b0; wbe = '0; rx_valid = 1'b0; tx_ready = 1'b0; inst_retire = 1'b0;

      st(A_TX, 32'hAB);
      push(8'h01); push(8'h02);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_reset_tx", {31'd0, tx_valid}, 32'd0);
      chk("mid_reset_rdata", rdata, 32'd0);
      chk("mid_reset_rx_ready", {31'd0, rx_ready}, 32'd1);
      ld(A_STATUS);
      chk("mid_reset_status", rdata, 32'h1);
      repeat (3) tick();
      chk("no_tx_replay", {31'd0, tx_valid}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
